// File: rtl/q_serializer_if.sv
// Handshake bundle for q_serializer: frame request and charge in, pulse stream and status out.
interface q_serializer_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 start;
  logic [BUS_WIDTH-1:0] q_value;
  logic                 q_serialized;
  logic                 busy;
  logic                 done;
  logic [BUS_WIDTH-1:0] pulses_sent;

  modport master (
    output start, q_value,
    input  q_serialized, busy, done, pulses_sent
  );

  modport slave (
    input  start, q_value,
    output q_serialized, busy, done, pulses_sent
  );
endinterface

// File: rtl/q_serializer.sv
// Charge-to-pulse serializer: emits floor(q_value / Q_PER_PULSE) fixed-width pulses, then a quiet tail.
// state | meaning
// IDLE  | waiting for start    HIGH | pulse high phase    LOW | inter-pulse gap
// TAIL  | frame closing quiet  DONE | one-cycle completion strobe
module q_serializer #(
  parameter int BUS_WIDTH      = 10,
  parameter int Q_PER_PULSE    = 30,
  parameter int PULSE_DURATION = 3,
  parameter int GAP_DURATION   = 3,
  parameter int TAIL_DURATION  = 8
) (
  input logic            clk,
  input logic            rst,
  q_serializer_if.slave  bus
);

  localparam int MAX_PG  = (PULSE_DURATION > GAP_DURATION) ? PULSE_DURATION : GAP_DURATION;
  localparam int MAX_DUR = (MAX_PG > TAIL_DURATION) ? MAX_PG : TAIL_DURATION;
  localparam int CNT_W   = $clog2(MAX_DUR + 1);

  localparam logic [BUS_WIDTH-1:0] Q_STEP     = BUS_WIDTH'(Q_PER_PULSE);
  localparam logic [CNT_W-1:0]     PULSE_LOAD = CNT_W'(PULSE_DURATION - 1);
  localparam logic [CNT_W-1:0]     GAP_LOAD   = CNT_W'(GAP_DURATION - 1);
  localparam logic [CNT_W-1:0]     TAIL_LOAD  = CNT_W'(TAIL_DURATION - 1);

  typedef enum logic [2:0] {IDLE, HIGH, LOW, TAIL, DONE} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [BUS_WIDTH-1:0] residual, residual_next;
  logic [BUS_WIDTH-1:0] pulses, pulses_next;
  logic                 q_ser_r, busy_r, done_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      residual <= '0;
      pulses   <= '0;
      q_ser_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      residual <= residual_next;
      pulses   <= pulses_next;
      // outputs decoded from the next state so they change on the same edge as the FSM
      q_ser_r  <= (state_next == HIGH);
      busy_r   <= (state_next == HIGH) || (state_next == LOW) || (state_next == TAIL);
      done_r   <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    residual_next = residual;
    pulses_next   = pulses;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          pulses_next = '0;
          if (bus.q_value >= Q_STEP) begin
            state_next    = HIGH;
            residual_next = bus.q_value - Q_STEP;
            cnt_next      = PULSE_LOAD;
          end else begin
            state_next    = TAIL;
            residual_next = bus.q_value;
            cnt_next      = TAIL_LOAD;
          end
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_next  = LOW;
          cnt_next    = GAP_LOAD;
          pulses_next = pulses + BUS_WIDTH'(1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt == '0) begin
          if (residual >= Q_STEP) begin
            state_next    = HIGH;
            residual_next = residual - Q_STEP;
            cnt_next      = PULSE_LOAD;
          end else begin
            state_next = TAIL;
            cnt_next   = TAIL_LOAD;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      TAIL: begin
        if (cnt == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.q_serialized = q_ser_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.pulses_sent  = pulses;

endmodule

// File: tb/tb_q_serializer.sv
// Self-checking bench for q_serializer: frame-timeline reference model plus directed and random frames.
module tb_q_serializer;
  localparam int BW  = 10;
  localparam int QP  = 30;
  localparam int PD  = 3;
  localparam int GD  = 3;
  localparam int TD  = 8;
  localparam int PER = PD + GD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  q_serializer_if #(.BUS_WIDTH(BW)) bus ();

  q_serializer #(
    .BUS_WIDTH(BW), .Q_PER_PULSE(QP), .PULSE_DURATION(PD),
    .GAP_DURATION(GD), .TAIL_DURATION(TD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference: a frame is n = q/QP pulses of PER cycles each, TD tail cycles, then one done cycle.
  logic m_active = 1'b0;
  int   m_k      = 0;
  int   m_n      = 0;
  int   m_hold   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_n      <= 0;
      m_hold   <= 0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_n      <= int'(bus.q_value) / QP;
      end
    end else if (m_k == m_n * PER + TD + 1) begin
      m_active <= 1'b0;
      m_hold   <= m_n;
    end else begin
      m_k <= m_k + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    int eq, eb, ed, ep, pos;
    eq = 0; eb = 0; ed = 0; ep = m_hold; pos = 0;
    if (m_active) begin
      if (m_k <= m_n * PER) begin
        pos = (m_k - 1) % PER;
        eq  = (pos < PD) ? 1 : 0;
        eb  = 1;
        ep  = (m_k - 1) / PER + ((pos >= PD) ? 1 : 0);
      end else if (m_k <= m_n * PER + TD) begin
        eb = 1;
        ep = m_n;
      end else begin
        ed = 1;
        ep = m_n;
      end
    end
    check("model q_serialized", int'(bus.q_serialized), eq);
    check("model busy", int'(bus.busy), eb);
    check("model done", int'(bus.done), ed);
    check("model pulses_sent", int'(bus.pulses_sent), ep);
  endtask

  task automatic tick();
    @(negedge clk);
    model_compare();
  endtask

  // Runs one frame; cycle 1 is the first cycle after the accepting edge.
  task automatic run_frame(input int q, input bit hold, input bit wait_first,
                           output int pulses, output int dcyc, output int psent,
                           output logic [31:0] hmap, output logic [31:0] bmap);
    logic prev;
    prev = 1'b0; pulses = 0; dcyc = -1; psent = -1; hmap = '0; bmap = '0;
    if (wait_first) tick();
    bus.start   = 1'b1;
    bus.q_value = BW'(q);
    tick();
    if (!hold) bus.start = 1'b0;
    bus.q_value = BW'($urandom);
    for (int c = 1; c <= 400; c++) begin
      if (bus.q_serialized && !prev) pulses++;
      prev = bus.q_serialized;
      if (c < 32) begin
        hmap[c] = bus.q_serialized;
        bmap[c] = bus.busy;
      end
      if (bus.done) begin
        dcyc  = c;
        psent = int'(bus.pulses_sent);
        break;
      end
      tick();
    end
    check("frame reached done", (dcyc >= 0) ? 1 : 0, 1);
  endtask

  int          np, dc, ps;
  logic [31:0] hm, bm;
  int          seen;

  initial begin
    bus.start   = 1'b0;
    bus.q_value = '0;
    #1;
    check("reset q_serialized", int'(bus.q_serialized), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset pulses_sent", int'(bus.pulses_sent), 0);
    tick();
    tick();
    rst = 1'b0;

    // q=95 accepted on the first edge after reset release
    run_frame(95, 1'b0, 1'b0, np, dc, ps, hm, bm);
    check("q95 pulses", np, 3);
    check("q95 done cycle", dc, 27);
    check("q95 pulses_sent", ps, 3);
    check("q95 high cycles", int'(hm), 32'h0000E38E);
    check("q95 busy cycles", int'(bm), 32'h07FFFFFE);
    check("q95 loopback", np * QP, 90);

    run_frame(0, 1'b0, 1'b1, np, dc, ps, hm, bm);
    check("q0 pulses", np, 0);
    check("q0 done cycle", dc, 9);
    check("q0 pulses_sent", ps, 0);
    check("q0 high cycles", int'(hm), 0);
    check("q0 busy cycles", int'(bm), 32'h000001FE);

    run_frame(1023, 1'b0, 1'b1, np, dc, ps, hm, bm);
    check("q1023 pulses", np, 34);
    check("q1023 done cycle", dc, 213);
    check("q1023 pulses_sent", ps, 34);

    run_frame(30, 1'b0, 1'b1, np, dc, ps, hm, bm);
    check("q30 loopback", np * QP, 30);
    check("q30 loopback vs pulses_sent", np * QP, ps * QP);

    run_frame(300, 1'b0, 1'b1, np, dc, ps, hm, bm);
    check("q300 done cycle", dc, 69);
    check("q300 loopback", np * QP, 300);
    check("q300 loopback vs pulses_sent", np * QP, ps * QP);

    // start held through the whole frame: one done, restart only from IDLE
    run_frame(60, 1'b1, 1'b1, np, dc, ps, hm, bm);
    check("q60 pulses", np, 2);
    check("q60 done cycle", dc, 21);
    check("q60 pulses_sent", ps, 2);
    bus.q_value = BW'(60);
    tick();
    check("q60 idle after done busy", int'(bus.busy), 0);
    check("q60 idle after done q", int'(bus.q_serialized), 0);
    check("q60 single done strobe", int'(bus.done), 0);
    tick();
    check("q60 restart pulse", int'(bus.q_serialized), 1);
    bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      tick();
    end
    check("q60 restart frame done", seen, 1);

    // asynchronous reset in the middle of a pulse
    tick();
    bus.start   = 1'b1;
    bus.q_value = BW'(95);
    tick();
    bus.start = 1'b0;
    tick();
    check("pre-reset high", int'(bus.q_serialized), 1);
    #2 rst = 1'b1;
    #1;
    check("async reset q_serialized", int'(bus.q_serialized), 0);
    check("async reset busy", int'(bus.busy), 0);
    check("async reset done", int'(bus.done), 0);
    check("async reset pulses_sent", int'(bus.pulses_sent), 0);
    tick();
    tick();
    tick();
    rst = 1'b0;
    run_frame(30, 1'b0, 1'b0, np, dc, ps, hm, bm);
    check("post-reset q30 pulses", np, 1);
    check("post-reset q30 done cycle", dc, 15);
    check("post-reset q30 pulses_sent", ps, 1);

    // random starts, values and occasional resets against the model
    for (int i = 0; i < 3000; i++) begin
      bus.start   = ($urandom_range(0, 5) == 0);
      bus.q_value = BW'($urandom_range(0, 400));
      rst         = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
